// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M execute-stage multiply/divide unit.
`timescale 1ns/1ps
package ex_muldiv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;
  localparam logic [2:0] F3_DIV     = 3'b100;
  localparam logic [2:0] F3_DIVU    = 3'b101;
  localparam logic [2:0] F3_REM     = 3'b110;
  localparam logic [2:0] F3_REMU    = 3'b111;

  localparam int         MD_ITER    = 32;
  localparam logic [5:0] CNT_LAST   = 6'(MD_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// One-bit-per-step datapath: shift-add multiply or restoring divide on a 2W-bit accumulator.
`timescale 1ns/1ps
module muldiv_shift_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_next_o
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   b_q, b_d;
  logic [W:0]     add_sum;
  logic [W:0]     rem_sh;
  logic [W-1:0]   diff;
  logic           borrow;

  // Multiply: {partial, multiplier} shifts right. Divide: {remainder, dividend/quotient} shifts left.
  always_comb begin
    add_sum = {1'b0, acc_q[2*W-1:W]} + ({(W+1){acc_q[0]}} & {1'b0, b_q});
    rem_sh  = acc_q[2*W-1:W-1];
    borrow  = rem_sh < {1'b0, b_q};
    diff    = rem_sh[W-1:0] - b_q;
    if (div_i) begin
      acc_next_o = borrow ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                          : {diff, acc_q[W-2:0], 1'b1};
    end else begin
      acc_next_o = {add_sum, acc_q[W-1:1]};
    end

    acc_d = acc_q;
    b_d   = b_q;
    if (load_i) begin
      acc_d = {{W{1'b0}}, a_i};
      b_d   = b_i;
    end else if (step_i) begin
      acc_d = acc_next_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide in EX: FSM, sign handling, special cases and pipeline hold.
// Build option MXRV_MUL_FAST_EN: multiplies complete in one cycle on a 33x33 signed multiplier.
`timescale 1ns/1ps
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      ex_muldiv_opcode_i,
  input  logic [2:0]      ex_muldiv_funct3_i,
  input  logic [6:0]      ex_muldiv_funct7_i,
  input  logic [4:0]      ex_muldiv_rd_i,
  input  logic [XLEN-1:0] ex_muldiv_rs1_data_i,
  input  logic [XLEN-1:0] ex_muldiv_rs2_data_i,
  input  logic            ex_muldiv_flush_i,
  output logic [XLEN-1:0] ex_muldiv_result_o,
  output logic [4:0]      ex_muldiv_rd_o,
  output logic            ex_muldiv_we_o,
  output logic            ex_muldiv_hold_req_o,
  output logic            ex_muldiv_busy_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              start, is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   rs1, rs2, mag_a, mag_b, div_sel, fixed;
  logic [2*XLEN-1:0] acc_next, prod;

  assign rs1 = ex_muldiv_rs1_data_i;
  assign rs2 = ex_muldiv_rs2_data_i;

`ifdef MXRV_MUL_FAST_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b;
  logic [2*XLEN-1:0]        fast_prod;
  // Sign-extended operands; the low 2*XLEN bits equal the 33x33 signed product.
  assign fast_a    = {{XLEN{a_sgn & rs1[XLEN-1]}}, rs1};
  assign fast_b    = {{XLEN{b_sgn & rs2[XLEN-1]}}, rs2};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    start    = is_m_op(ex_muldiv_opcode_i, ex_muldiv_funct7_i)
               && (state_q == ST_IDLE) && !ex_muldiv_flush_i;
    is_div   = ex_muldiv_funct3_i[2];
    a_sgn    = (ex_muldiv_funct3_i == F3_MULH) || (ex_muldiv_funct3_i == F3_MULHSU)
               || (ex_muldiv_funct3_i == F3_DIV) || (ex_muldiv_funct3_i == F3_REM);
    b_sgn    = (ex_muldiv_funct3_i == F3_MULH) || (ex_muldiv_funct3_i == F3_DIV)
               || (ex_muldiv_funct3_i == F3_REM);
    a_neg    = a_sgn & rs1[XLEN-1];
    b_neg    = b_sgn & rs2[XLEN-1];
    mag_a    = a_neg ? -rs1 : rs1;
    mag_b    = b_neg ? -rs2 : rs2;
    div_zero = is_div && (rs2 == '0);
    div_ovf  = is_div && !ex_muldiv_funct3_i[0] && (rs1 == INT_MIN) && (rs2 == '1);

    // Result sign is applied to the full product so MULH* sees the borrow from the low half.
    prod    = neg_q ? -acc_next : acc_next;
    div_sel = f3_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (f3_q[2])               fixed = neg_q ? -div_sel : div_sel;
    else if (f3_q == F3_MUL)   fixed = prod[XLEN-1:0];
    else                       fixed = prod[2*XLEN-1:XLEN];

    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    result_d = result_q;

    if (ex_muldiv_flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            f3_d  = ex_muldiv_funct3_i;
            rd_d  = ex_muldiv_rd_i;
            neg_d = (is_div && ex_muldiv_funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
            cnt_d = '0;
            if (div_zero) begin
              state_d  = ST_DONE;
              result_d = ex_muldiv_funct3_i[1] ? rs1 : '1;
            end else if (div_ovf) begin
              state_d  = ST_DONE;
              result_d = ex_muldiv_funct3_i[1] ? '0 : INT_MIN;
            end
`ifdef MXRV_MUL_FAST_EN
            else if (!is_div) begin
              state_d  = ST_DONE;
              result_d = (ex_muldiv_funct3_i == F3_MUL) ? fast_prod[XLEN-1:0]
                                                        : fast_prod[2*XLEN-1:XLEN];
            end
`endif
            else begin
              state_d = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_DONE;
            result_d = fixed;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  muldiv_shift_core #(.W(XLEN)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start),
    .step_i     ((state_q == ST_BUSY) && !ex_muldiv_flush_i),
    .div_i      (f3_q[2]),
    .a_i        (mag_a),
    .b_i        (mag_b),
    .acc_next_o (acc_next)
  );

  // Hold is also masked by reset so an instruction parked at the inputs cannot stall a reset pipeline.
  assign ex_muldiv_hold_req_o = rst_n && (start || ((state_q == ST_BUSY) && !ex_muldiv_flush_i));
  assign ex_muldiv_we_o       = (state_q == ST_DONE) && !ex_muldiv_flush_i;
  assign ex_muldiv_busy_o     = (state_q == ST_BUSY);
  assign ex_muldiv_result_o   = result_q;
  assign ex_muldiv_rd_o       = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, control scenarios and random ops vs. a reference model.
`timescale 1ns/1ps
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we, hold, busy;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ex_muldiv_opcode_i   (opcode),
    .ex_muldiv_funct3_i   (funct3),
    .ex_muldiv_funct7_i   (funct7),
    .ex_muldiv_rd_i       (rd),
    .ex_muldiv_rs1_data_i (rs1),
    .ex_muldiv_rs2_data_i (rs2),
    .ex_muldiv_flush_i    (flush),
    .ex_muldiv_result_o   (result),
    .ex_muldiv_rd_o       (rd_out),
    .ex_muldiv_we_o       (we),
    .ex_muldiv_hold_req_o (hold),
    .ex_muldiv_busy_o     (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ub;
    longint unsigned uua, uub;
    logic [63:0]     p;
    int              sa32, sb32;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'h0, b});
    uua  = {32'h0, a};
    uub  = {32'h0, b};
    sa32 = $signed(a);
    sb32 = $signed(b);
    case (f3)
      3'd0: begin p = uua * uub; return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub;   return p[63:32]; end
      3'd3: begin p = uua * uub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa32 / sb32;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa32 % sb32;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from start to write-back strobe (equal to the number of hold cycles).
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MXRV_MUL_FAST_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_idle();
    opcode = 7'h0; funct3 = 3'h0; funct7 = 7'h0; rd = 5'h0; rs1 = 32'h0; rs2 = 32'h0;
  endtask

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = f3; rd = r; rs1 = a; rs2 = b;
  endtask

  // Issue one M instruction held stable until write-back, then retire it from the inputs.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    int lat, k, holds;
    logic seen;
    logic [31:0] exp;
    exp_q.push_back(ref_result(f3, a, b));
    lat = ref_latency(f3, a, b);
    @(negedge clk);
    drive_m(f3, a, b, r);
    k = 0; holds = 0; seen = 1'b0;
    while (!seen && k <= 60) begin
      #1;
      if (we === 1'b1) seen = 1'b1;
      else begin
        if (hold === 1'b1) holds++;
        @(negedge clk);
        k++;
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen || k != lat) $display("FAIL latency f3=%0d a=%h b=%h: we at cycle %0d (seen=%0b), expected %0d", f3, a, b, k, seen, lat);
    else passed++;
    if (seen) begin
      checks++;
      if (holds != lat) $display("FAIL hold_cycles f3=%0d a=%h b=%h: got %0d, expected %0d", f3, a, b, holds, lat);
      else passed++;
      checks++;
      if (result !== exp) $display("FAIL result f3=%0d a=%h b=%h: got %h, expected %h", f3, a, b, result, exp);
      else passed++;
      checks++;
      if (rd_out !== r) $display("FAIL rd f3=%0d: got %0d, expected %0d", f3, rd_out, r);
      else passed++;
      checks++;
      if (hold !== 1'b0) $display("FAIL hold_in_done f3=%0d: got %b, expected 0", f3, hold);
      else passed++;
    end
    drive_idle();
    @(negedge clk);
    #1;
    checks++;
    if ({we, busy} !== 2'b00) $display("FAIL after_done f3=%0d: we/busy=%b, expected 00", f3, {we, busy});
    else passed++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({result, rd_out, we, hold, busy} !== 40'h0) $display("FAIL reset_outputs: got %h, expected 0", {result, rd_out, we, hold, busy});
    else passed++;
    drive_m(3'd0, 32'd7, 32'd6, 5'd5);
    #1;
    checks++;
    if (hold !== 1'b0) $display("FAIL reset_hold: got %b, expected 0", hold);
    else passed++;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd7, 32'd6, 5'd5);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    run_op(3'd0, 32'd3, 32'd4, 5'd0);
    run_op(3'd1, 32'h8000_0000, 32'd3, 5'd9);
  endtask

  task automatic test_div();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);
    run_op(3'd5, 32'd100, 32'd7, 5'd12);
    run_op(3'd7, 32'd100, 32'd7, 5'd13);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd14);
  endtask

  task automatic test_special();
    run_op(3'd4, 32'd5, 32'd0, 5'd1);
    run_op(3'd6, 32'd5, 32'd0, 5'd2);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 5'd15);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd0, 5'd16);
  endtask

  task automatic test_non_m();
    logic [6:0] opc [3];
    logic [6:0] f7  [3];
    opc[0] = 7'b0110011; f7[0] = 7'b0000000;
    opc[1] = 7'b0110011; f7[1] = 7'b0100000;
    opc[2] = 7'b0111011; f7[2] = 7'b0000001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = opc[i]; funct7 = f7[i]; funct3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(1, 31)); rs1 = $urandom; rs2 = $urandom;
      for (int c = 0; c < 3; c++) begin
        #1;
        checks++;
        if ({hold, we, busy} !== 3'b000) $display("FAIL non_m pattern %0d cycle %0d: hold/we/busy=%b, expected 000", i, c, {hold, we, busy});
        else passed++;
        @(negedge clk);
      end
    end
    drive_idle();
  endtask

  task automatic test_flush();
    int wes;
    @(negedge clk);
    drive_m(3'd5, 32'd1000, 32'd3, 5'd9);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if ({hold, we, busy} !== 3'b001) $display("FAIL flush_same_cycle: hold/we/busy=%b, expected 001", {hold, we, busy});
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({hold, we, busy} !== 3'b000) $display("FAIL flush_next_cycle: hold/we/busy=%b, expected 000", {hold, we, busy});
    else passed++;
    flush = 1'b0;
    drive_idle();
    wes = 0;
    repeat (40) begin @(negedge clk); if (we === 1'b1) wes++; end
    checks++;
    if (wes != 0) $display("FAIL flush_no_we: got %0d strobes, expected 0", wes);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int wes;
    @(negedge clk);
    drive_m(3'd0, 32'd123, 32'd456, 5'd17);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy: got %b, expected 1", busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({result, rd_out, we, hold, busy} !== 40'h0) $display("FAIL reset_mid_outputs: got %h, expected 0", {result, rd_out, we, hold, busy});
    else passed++;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    wes = 0;
    repeat (40) begin @(negedge clk); if (we === 1'b1) wes++; end
    checks++;
    if (wes != 0) $display("FAIL reset_mid_no_we: got %0d strobes, expected 0", wes);
    else passed++;
  endtask

  // The same MUL stays at the inputs: no restart from DONE, next start one cycle later.
  task automatic test_back_to_back();
    int lat, lows;
    int we_at[$];
    logic [31:0] exp;
    lat = ref_latency(3'd0, 32'd5, 32'd9);
    exp = ref_result(3'd0, 32'd5, 32'd9);
    @(negedge clk);
    drive_m(3'd0, 32'd5, 32'd9, 5'd3);
    lows = 0;
    for (int k = 0; k <= 2 * lat + 2; k++) begin
      #1;
      if (we === 1'b1) begin
        we_at.push_back(k);
        checks++;
        if (result !== exp) $display("FAIL b2b_result at %0d: got %h, expected %h", k, result, exp);
        else passed++;
      end
      if (hold !== 1'b1) lows++;
      @(negedge clk);
    end
    checks++;
    if (we_at.size() != 2) $display("FAIL b2b_we_count: got %0d, expected 2", we_at.size());
    else passed++;
    if (we_at.size() == 2) begin
      checks++;
      if (we_at[0] != lat || we_at[1] != 2 * lat + 1)
        $display("FAIL b2b_we_cycles: got %0d,%0d, expected %0d,%0d", we_at[0], we_at[1], lat, 2 * lat + 1);
      else passed++;
    end
    checks++;
    if (lows != 2) $display("FAIL b2b_hold_low_cycles: got %0d, expected 2", lows);
    else passed++;
    drive_idle();
    repeat (40) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive_idle();
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_non_m();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
